// File: rtl/display_mux_ctrl.sv
// Dual-digit display sequencer: key history plus blanked time-multiplexing.
// Optional LEADING_BLANK_EN keeps digits dark until they hold a key.
module display_mux_ctrl #(
    parameter logic [23:0] REFRESH_DIVIDER = 24'd60000,
    parameter logic [23:0] BLANK_CYCLES    = 24'd480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_key,
    input  logic [3:0] digit,
    output logic [3:0] seg_digit,
    output logic       en_left,
    output logic       en_right,
    output logic [3:0] digit_left,
    output logic [3:0] digit_right
);

    typedef enum logic [1:0] {
        BLANK_R2L  = 2'd0,
        SHOW_LEFT  = 2'd1,
        BLANK_L2R  = 2'd2,
        SHOW_RIGHT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [23:0] term;
    logic        show_l, show_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_left  <= 4'd0;
            digit_right <= 4'd0;
        end else if (valid_key) begin
            digit_left  <= digit_right;
            digit_right <= digit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BLANK_R2L;
            cnt   <= 24'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 24'd1;
        term      = BLANK_CYCLES - 24'd1;
        unique case (state)
            SHOW_LEFT,
            SHOW_RIGHT: term = REFRESH_DIVIDER - 24'd1;
            default:    term = BLANK_CYCLES - 24'd1;
        endcase
        if (cnt == term) begin
            cnt_nxt = 24'd0;
            unique case (state)
                BLANK_R2L:  state_nxt = SHOW_LEFT;
                SHOW_LEFT:  state_nxt = BLANK_L2R;
                BLANK_L2R:  state_nxt = SHOW_RIGHT;
                SHOW_RIGHT: state_nxt = BLANK_R2L;
                default:    state_nxt = BLANK_R2L;
            endcase
        end
    end

    assign show_l = (state == SHOW_LEFT);
    assign show_r = (state == SHOW_RIGHT);

    // Decoder input switches at the start of each blank, ahead of the enable
    assign seg_digit = (state == BLANK_R2L || state == SHOW_LEFT)
                     ? digit_left : digit_right;

`ifdef LEADING_BLANK_EN
    logic [1:0] key_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            key_count <= 2'd0;
        else if (valid_key && key_count != 2'd2)
            key_count <= key_count + 2'd1;
    end

    assign en_left  = show_l && (key_count == 2'd2);
    assign en_right = show_r && (key_count != 2'd0);
`else
    assign en_left  = show_l;
    assign en_right = show_r;
`endif

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl with DIV=4, BLANK=2 (12-cycle period).
module tb_display_mux_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_key = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [3:0] seg_digit;
    logic       en_left, en_right;
    logic [3:0] digit_left, digit_right;

    int         n_tests = 0;
    int         n_fail = 0;
    int         k = 0;
    int         exp_kc = 0;
    logic [3:0] exp_l = 4'd0;
    logic [3:0] exp_r = 4'd0;

    // Index = (cycles since release - 1) mod 12; {en_left,en_right}
    logic [1:0] en_tab [12] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                                2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic       sel_r  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    display_mux_ctrl #(
        .REFRESH_DIVIDER(24'd4),
        .BLANK_CYCLES   (24'd2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_key  (valid_key),
        .digit      (digit),
        .seg_digit  (seg_digit),
        .en_left    (en_left),
        .en_right   (en_right),
        .digit_left (digit_left),
        .digit_right(digit_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_cycle();
        int         idx;
        logic [1:0] en;
        idx = (k - 1) % 12;
        en  = en_tab[idx];
`ifdef LEADING_BLANK_EN
        if (exp_kc < 2) en[1] = 1'b0;
        if (exp_kc < 1) en[0] = 1'b0;
`endif
        chk("en", {30'd0, en_left, en_right}, {30'd0, en});
        chk("seg", {28'd0, seg_digit},
            {28'd0, (sel_r[idx] ? exp_r : exp_l)});
        chk("excl", {31'd0, en_left & en_right}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic key(input logic [3:0] d);
        valid_key = 1'b1;
        digit     = d;
        exp_l     = exp_r;
        exp_r     = d;
        if (exp_kc < 2) exp_kc++;
        step();
        valid_key = 1'b0;
        digit     = 4'd0;
        chk("dl", {28'd0, digit_left}, {28'd0, exp_l});
        chk("dr", {28'd0, digit_right}, {28'd0, exp_r});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"}, {30'd0, en_left, en_right}, 32'd0);
        chk({tag, "_seg"}, {28'd0, seg_digit}, 32'd0);
        chk({tag, "_dl"}, {28'd0, digit_left}, 32'd0);
        chk({tag, "_dr"}, {28'd0, digit_right}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b1;
        k = 0;
        repeat (24) step();

        key(4'h5);
        while (k < 36) step();

        key(4'h3);
        key(4'hA);
        while (k < 43) step();

        // Lands on the last BLANK_L2R count; SHOW_RIGHT must open with 7
        key(4'h7);
        while (k < 57) step();

        #2 reset = 1'b0;
        #1 chk_reset("midrst");
        exp_l  = 4'd0;
        exp_r  = 4'd0;
        exp_kc = 0;
        @(negedge clk);
        chk_reset("held");
        reset = 1'b1;
        k = 0;
        repeat (14) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
